// File: rtl/trap_sequencer.sv
// Machine-mode trap CSR file and trap-entry / mret sequencer driving fetch redirect and pipeline stall.
// Optional trap counter CSR at 0x7C0 is enabled with `define TRAP_SEQUENCER_COUNTER_EN.
module trap_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter int unsigned     DRAIN_CYCLES = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            trapValid,
  input  logic [3:0]      trapCause,
  input  logic [XLEN-1:0] trapValue,
  input  logic [XLEN-1:0] trapPc,
  input  logic            mretValid,
  input  logic            csrWriteValid,
  output logic            csrWriteReady,
  input  logic [11:0]     csrWriteAddr,
  input  logic [XLEN-1:0] csrWriteData,
  input  logic [11:0]     csrReadAddr,
  output logic [XLEN-1:0] csrReadData,
  output logic            stallControl,
  output logic            redirectValid,
  output logic [XLEN-1:0] redirectPc,
  output logic            interruptEnable
);

  typedef enum logic [2:0] {
    IDLE,
    TRAP_SAVE,
    MRET_RESTORE,
    REDIRECT,
    DRAIN
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
`ifdef TRAP_SEQUENCER_COUNTER_EN
  localparam logic [11:0] ADDR_TRAPCNT  = 12'h7C0;
`endif

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [3:0]      DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t          state, state_next;
  logic [3:0]      drain_cnt;
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mtval;
  logic [3:0]      mcause;
  logic [XLEN-1:0] trap_pc, trap_value;
  logic [3:0]      trap_cause;
`ifdef TRAP_SEQUENCER_COUNTER_EN
  logic [31:0]     trap_count;
`endif

  // NOTE: every output and next-state value gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_next    = state;
    stallControl  = 1'b1;
    redirectValid = 1'b0;
    csrWriteReady = 1'b0;
    case (state)
      IDLE: begin
        stallControl  = trapValid || mretValid;
        csrWriteReady = reset && !trapValid && !mretValid && csrWriteValid;
        if (trapValid)      state_next = TRAP_SAVE;
        else if (mretValid) state_next = MRET_RESTORE;
      end
      TRAP_SAVE, MRET_RESTORE: state_next = REDIRECT;
      REDIRECT: begin
        // A reset arriving during the pulse cancels it, so fetch never sees a half-aborted redirect.
        redirectValid = reset;
        state_next    = DRAIN;
      end
      DRAIN: if (drain_cnt <= 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      mie        <= 1'b0;
      mpie       <= 1'b0;
      mtvec      <= MTVEC_RESET;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
      trap_pc    <= '0;
      trap_value <= '0;
      trap_cause <= '0;
      redirectPc <= '0;
`ifdef TRAP_SEQUENCER_COUNTER_EN
      trap_count <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (trapValid) begin
          trap_pc    <= trapPc;
          trap_cause <= trapCause;
          trap_value <= trapValue;
        end
        TRAP_SAVE: begin
          mepc       <= trap_pc & ALIGN_MASK;
          mcause     <= trap_cause;
          mtval      <= trap_value;
          mpie       <= mie;
          mie        <= 1'b0;
          redirectPc <= mtvec & ALIGN_MASK;
`ifdef TRAP_SEQUENCER_COUNTER_EN
          trap_count <= trap_count + 32'd1;
`endif
        end
        MRET_RESTORE: begin
          mie        <= mpie;
          mpie       <= 1'b1;
          redirectPc <= mepc;
        end
        REDIRECT: drain_cnt <= DRAIN_INIT;
        DRAIN:    drain_cnt <= drain_cnt - 4'd1;
        default:  ;
      endcase

      // Software writes only land in IDLE, so they never collide with the sequencer's own updates.
      if (csrWriteReady) begin
        case (csrWriteAddr)
          ADDR_MSTATUS: begin
            mie  <= csrWriteData[3];
            mpie <= csrWriteData[7];
          end
          ADDR_MTVEC:    mtvec    <= csrWriteData;
          ADDR_MSCRATCH: mscratch <= csrWriteData;
          ADDR_MEPC:     mepc     <= csrWriteData & ALIGN_MASK;
          ADDR_MCAUSE:   mcause   <= csrWriteData[3:0];
          ADDR_MTVAL:    mtval    <= csrWriteData;
          default:       ;
        endcase
      end
    end
  end

  always_comb begin
    csrReadData = '0;
    case (csrReadAddr)
      ADDR_MSTATUS: begin
        csrReadData[3]     = mie;
        csrReadData[7]     = mpie;
        csrReadData[12:11] = 2'b11;
      end
      ADDR_MTVEC:    csrReadData = mtvec & ALIGN_MASK;
      ADDR_MSCRATCH: csrReadData = mscratch;
      ADDR_MEPC:     csrReadData = mepc;
      ADDR_MCAUSE:   csrReadData = {{(XLEN-4){1'b0}}, mcause};
      ADDR_MTVAL:    csrReadData = mtval;
`ifdef TRAP_SEQUENCER_COUNTER_EN
      ADDR_TRAPCNT:  csrReadData = XLEN'(trap_count);
`endif
      default:       csrReadData = '0;
    endcase
  end

  assign interruptEnable = mie;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed test-plan steps plus randomized traffic
// checked against a transaction-level model of the CSR file and sequence timing.
module tb_trap_sequencer;

  localparam int          XLEN  = 32;
  localparam int          DRAIN = 3;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        trapValid = 1'b0;
  logic [3:0]  trapCause = '0;
  logic [31:0] trapValue = '0;
  logic [31:0] trapPc = '0;
  logic        mretValid = 1'b0;
  logic        csrWriteValid = 1'b0;
  logic        csrWriteReady;
  logic [11:0] csrWriteAddr = '0;
  logic [31:0] csrWriteData = '0;
  logic [11:0] csrReadAddr = '0;
  logic [31:0] csrReadData;
  logic        stallControl;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        interruptEnable;

  trap_sequencer #(
    .XLEN(XLEN), .MTVEC_RESET(32'h0000_0000), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clock(clock), .reset(reset),
    .trapValid(trapValid), .trapCause(trapCause), .trapValue(trapValue), .trapPc(trapPc),
    .mretValid(mretValid),
    .csrWriteValid(csrWriteValid), .csrWriteReady(csrWriteReady),
    .csrWriteAddr(csrWriteAddr), .csrWriteData(csrWriteData),
    .csrReadAddr(csrReadAddr), .csrReadData(csrReadData),
    .stallControl(stallControl), .redirectValid(redirectValid), .redirectPc(redirectPc),
    .interruptEnable(interruptEnable)
  );

  always #10 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Architectural model of the CSR state.
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mtval, m_rpc, m_count;
  logic [3:0]  m_mcause;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = 32'h0; m_mscratch = 0; m_mepc = 0; m_mtval = 0; m_mcause = 0;
    m_rpc = 0; m_count = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    case (a)
      12'h300: return {19'b0, 2'b11, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
      12'h305: return m_mtvec & ALIGN;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return {28'b0, m_mcause};
      12'h343: return m_mtval;
`ifdef TRAP_SEQUENCER_COUNTER_EN
      12'h7C0: return m_count;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_csrs(input string tag);
    logic [11:0] addrs [9];
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7C0, 12'hF11, 12'h301};
    for (int i = 0; i < 9; i++) begin
      csrReadAddr = addrs[i];
      #1;
      check($sformatf("%s_rd_%h", tag, addrs[i]), csrReadData, exp_read(addrs[i]));
    end
    check({tag, "_ie"}, interruptEnable, m_mie);
  endtask

  task automatic read_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csrReadAddr = a;
    #1;
    check(tag, csrReadData, exp);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csrWriteAddr = a; csrWriteData = d; csrWriteValid = 1;
    #1;
    check("wr_ready", csrWriteReady, 1'b1);
    step();
    csrWriteValid = 0;
    case (a)
      12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
      12'h305: m_mtvec = d;
      12'h340: m_mscratch = d;
      12'h341: m_mepc = d & ALIGN;
      12'h342: m_mcause = d[3:0];
      12'h343: m_mtval = d;
      default: ;
    endcase
  endtask

  // Trigger has been driven; walk the fixed-length sequence while injecting ignored requests.
  task automatic run_seq(input logic [31:0] target, input bit hold_wr);
    for (int i = 1; i <= 2 + DRAIN; i++) begin
      step();
      check($sformatf("seq%0d_stall", i), stallControl, 1'b1);
      check($sformatf("seq%0d_rvalid", i), redirectValid, (i == 2));
      if (i >= 2) m_rpc = target;
      check($sformatf("seq%0d_rpc", i), redirectPc, m_rpc);
      if (i < 2 + DRAIN) begin
        trapValid = 1'($urandom_range(0, 1));
        mretValid = 1'($urandom_range(0, 1));
        trapPc    = $urandom;
      end else begin
        trapValid = 0;
        mretValid = 0;
      end
      if (!hold_wr) begin
        csrWriteValid = (i < 2 + DRAIN) ? 1'($urandom_range(0, 1)) : 1'b0;
        csrWriteAddr  = ($urandom_range(0, 1) == 1) ? 12'h340 : 12'h305;
        csrWriteData  = $urandom;
      end
      #1;
      check($sformatf("seq%0d_wready", i), csrWriteReady, 1'b0);
    end
    step();
    check("seq_end_stall", stallControl, 1'b0);
    check("seq_end_rvalid", redirectValid, 1'b0);
    check("seq_end_rpc", redirectPc, m_rpc);
    check("seq_end_wready", csrWriteReady, hold_wr);
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [3:0] cause, input logic [31:0] val,
                         input bit with_mret, input bit with_wr, input logic [31:0] wdata);
    logic [31:0] target;
    trapValid = 1; trapPc = pc; trapCause = cause; trapValue = val;
    mretValid = with_mret;
    csrWriteValid = with_wr; csrWriteAddr = 12'h340; csrWriteData = wdata;
    #1;
    check("trig_stall", stallControl, 1'b1);
    check("trig_wready", csrWriteReady, 1'b0);
    target = m_mtvec & ALIGN;
    m_mepc = pc & ALIGN; m_mcause = cause; m_mtval = val;
    m_mpie = m_mie; m_mie = 0;
    m_count = m_count + 1;
    run_seq(target, with_wr);
    if (with_wr) begin
      step();
      csrWriteValid = 0;
      m_mscratch = wdata;
    end
    check("trap_ie", interruptEnable, m_mie);
  endtask

  task automatic do_mret();
    logic [31:0] target;
    mretValid = 1;
    #1;
    check("mret_stall", stallControl, 1'b1);
    target = m_mepc;
    m_mie = m_mpie; m_mpie = 1;
    run_seq(target, 1'b0);
    check("mret_ie", interruptEnable, m_mie);
  endtask

  initial begin
    logic [11:0] waddrs [9];
    waddrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7C0, 12'hF11, 12'h301};
    model_reset();

    // Reset: outputs idle and software writes refused while reset is low.
    csrWriteValid = 1; csrWriteAddr = 12'h340; csrWriteData = 32'h5555_5555;
    step(); step();
    check("rst_stall", stallControl, 1'b0);
    check("rst_rvalid", redirectValid, 1'b0);
    check("rst_rpc", redirectPc, 32'h0);
    check("rst_wready", csrWriteReady, 1'b0);
    csrWriteValid = 0;
    reset = 1;
    step();
    check_csrs("reset");

    // Trap entry.
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h300, 32'h0000_0008);
    do_trap(32'h0000_2046, 4'h2, 32'hDEAD_BEEF, 0, 0, 32'h0);
    check("trap_rpc_const", redirectPc, 32'h0000_0100);
    read_expect("trap_mepc_const", 12'h341, 32'h0000_2044);
    read_expect("trap_mcause_const", 12'h342, 32'h2);
    read_expect("trap_mtval_const", 12'h343, 32'hDEAD_BEEF);
    read_expect("trap_mstatus_const", 12'h300, 32'h0000_1880);
    check_csrs("trap");

    // mret return.
    step();
    csr_write(12'h341, 32'h0000_2048);
    csr_write(12'h300, 32'h0000_0080);
    do_mret();
    check("mret_rpc_const", redirectPc, 32'h0000_2048);
    read_expect("mret_mstatus_const", 12'h300, 32'h0000_1888);
    check_csrs("mret");

    // Trap, mret and software write in the same cycle.
    step();
    do_trap(32'h0000_3000, 4'h5, 32'h0000_0042, 1, 1, 32'h1234_5678);
    read_expect("prio_mscratch_const", 12'h340, 32'h1234_5678);
    check_csrs("prio");

    // Masked and ignored writes.
    step();
    csr_write(12'h341, 32'hFFFF_FFFF);
    read_expect("mask_mepc", 12'h341, 32'hFFFF_FFFC);
    step();
    csr_write(12'h305, 32'h0000_1233);
    read_expect("mask_mtvec", 12'h305, 32'h0000_1230);
    step();
    csr_write(12'h342, 32'h0000_0007);
    read_expect("mcause_wr", 12'h342, 32'h0000_0007);
    step();
    csr_write(12'hF11, 32'hCAFE_F00D);
    read_expect("unknown_rd", 12'hF11, 32'h0);
    step();
    csr_write(12'h7C0, 32'hCAFE_F00D);
    check_csrs("masked");

    // Reset while the redirect pulse is due.
    step();
    trapValid = 1; trapPc = 32'h0000_4444; trapCause = 4'h3; trapValue = 32'h0000_0099;
    step();
    trapValid = 0;
    step();
    check("rstmid_rvalid_before", redirectValid, 1'b1);
    reset = 0;
    #1;
    check("rstmid_rvalid_gated", redirectValid, 1'b0);
    step();
    reset = 1;
    model_reset();
    check("rstmid_stall", stallControl, 1'b0);
    check("rstmid_rvalid", redirectValid, 1'b0);
    check("rstmid_rpc", redirectPc, 32'h0);
    check("rstmid_wready", csrWriteReady, 1'b0);
    check_csrs("rstmid");
    step(); step();
    check("rstmid_later_rvalid", redirectValid, 1'b0);
    check("rstmid_later_stall", stallControl, 1'b0);
    step();
    csr_write(12'h340, 32'h0000_00AA);

    // Trap counter: three traps and one mret.
    for (int k = 0; k < 3; k++) do_trap($urandom, 4'($urandom_range(0, 15)), $urandom, 0, 0, 32'h0);
    do_mret();
`ifdef TRAP_SEQUENCER_COUNTER_EN
    read_expect("count_three", 12'h7C0, 32'd3);
    step();
    force dut.trap_count = 32'hFFFF_FFFF;
    step();
    release dut.trap_count;
    m_count = 32'hFFFF_FFFF;
    do_trap(32'h0000_0100, 4'h1, 32'h0, 0, 0, 32'h0);
    read_expect("count_wrap", 12'h7C0, 32'd0);
`else
    read_expect("count_absent", 12'h7C0, 32'd0);
`endif
    check_csrs("count");

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      step();
      case ($urandom_range(0, 3))
        0: csr_write(waddrs[$urandom_range(0, 8)], $urandom);
        1: do_trap($urandom, 4'($urandom_range(0, 15)), $urandom, 0, 0, 32'h0);
        2: do_mret();
        default: do_trap($urandom, 4'($urandom_range(0, 15)), $urandom, 1, 1, $urandom);
      endcase
      check_csrs($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Owns the machine-mode trap CSRs: mstatus.MIE/MPIE, mtvec, mscratch, mepc, mcause, mtval.
- Sequences trap entry and mret return as a multi-cycle FSM: saves state, redirects fetch, then holds the pipeline stalled while the flush drains.
- Arbitrates the single CSR write path between trap entry, mret restore and software CSR writes from execute.
- Sits beside the pipeline hazard unit. It consumes that unit's trap outputs (cause/value) and drives its stallControl input.

Parameters:
- XLEN, 32, datapath/CSR width.
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset.
- DRAIN_CYCLES, 3, cycles stall is held after redirect (range 1..15).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset: synchronous, active-low
- trapValid  in  1  trap taken this cycle (hazard controlReset)
- trapCause  in  4  mcause code from hazard unit
- trapValue  in  XLEN  mtval from hazard unit
- trapPc  in  XLEN  PC of faulting instruction (memory/writeback stage)
- mretValid  in  1  mret retiring
- csrWriteValid  in  1  software CSR write request
- csrWriteReady  out  1  write accepted this cycle
- csrWriteAddr  in  12  CSR address
- csrWriteData  in  XLEN  write data
- csrReadAddr  in  12  CSR read address
- csrReadData  out  XLEN  combinational read data; 0 for unimplemented addresses
- stallControl  out  1  stall all pipeline stages
- redirectValid  out  1  one-cycle fetch redirect pulse
- redirectPc  out  XLEN  redirect target
- interruptEnable  out  1  current mstatus.MIE

Behaviour:
- **Reset** (reset==0 at posedge):
  - state=IDLE, drain counter=0.
  - mtvec=MTVEC_RESET; mepc, mcause, mtval, mscratch = 0; MIE=0, MPIE=0.
  - stallControl=0, redirectValid=0, redirectPc=0, csrWriteReady=0.
  - Reset mid-sequence aborts the sequence; no redirect is issued.
- **CSR map** (read):
  - mstatus 0x300: bit3=MIE, bit7=MPIE, bits12:11=2'b11, other bits 0.
  - mtvec 0x305: bits1:0 read 0 (direct mode only).
  - mscratch 0x340, mepc 0x341 (bits1:0 forced 0 on every write), mcause 0x342 (4-bit, zero-extended), mtval 0x343.
  - Writes to read-only or unknown addresses are accepted and ignored.
- **Arbitration** (IDLE only), priority trap > mret > software write:
  - csrWriteReady = IDLE && reset && !trapValid && !mretValid && csrWriteValid.
  - A write takes effect at the same edge it is accepted.
- **FSM states:** IDLE, TRAP_SAVE, MRET_RESTORE, REDIRECT, DRAIN.
- **IDLE:**
  - trapValid → latch trapPc, trapCause, trapValue; go to TRAP_SAVE.
  - else mretValid → go to MRET_RESTORE.
- **TRAP_SAVE** (1 cycle): mepc={trapPc[31:2],2'b00}, mcause=trapCause, mtval=trapValue, MPIE=MIE, MIE=0; go to REDIRECT, target={mtvec[31:2],2'b00}.
- **MRET_RESTORE** (1 cycle): MIE=MPIE, MPIE=1; go to REDIRECT, target=mepc.
- **REDIRECT** (1 cycle): redirectValid=1, redirectPc=target; load drain counter=DRAIN_CYCLES; go to DRAIN.
- **DRAIN:** decrement the counter each cycle; at count 1 → IDLE.
- **Stall and redirect outputs:**
  - stallControl=1 in every non-IDLE state, and combinationally in IDLE when trapValid or mretValid is high.
  - redirectValid=0 and redirectPc holds its last value outside REDIRECT.
- **Ignored inputs:** trapValid and mretValid are ignored in all non-IDLE states (the pipeline is being flushed). csrWriteValid outside IDLE is held off, not dropped.
- **Latency:** trapValid edge to redirectValid = 2 cycles; stall held for 2+DRAIN_CYCLES cycles after the trigger cycle.
- **Simultaneous events:** trapValid and mretValid together → trap wins; mret is discarded.

Optional Feature:
- Macro: TRAP_SEQUENCER_COUNTER_EN.
- **Defined:**
  - Adds a 32-bit trap counter CSR at 0x7C0; read-only to software, reset 0.
  - Increments by 1 in TRAP_SAVE; wraps 0xFFFF_FFFF→0.
  - mret does not count.
- **Undefined:** no counter register; 0x7C0 reads 0.

Test Plan:
- **Trap entry:** mtvec=0x0000_0100, MIE=1, then trapValid with trapPc=0x0000_2046, cause=0x2, value=0xDEAD_BEEF.
  - Expect redirectValid exactly 2 cycles later with redirectPc=0x100.
  - Expect mepc=0x2044, mcause=2, mtval=0xDEADBEEF, MIE=0, MPIE=1.
  - Expect stallControl high for 5 cycles.
- **mret return:** mepc=0x2048, MPIE=1, MIE=0, then mretValid.
  - Expect redirectPc=0x2048 after 2 cycles, MIE=1, MPIE=1.
- **Priority and arbitration:**
  - trapValid + mretValid + csrWriteValid in the same cycle → trap sequence runs, csrWriteReady=0, mret ignored.
  - The pending csr write is accepted the first cycle back in IDLE.
- **Reset mid-sequence:** reset low in REDIRECT.
  - Next cycle: state IDLE, stall=0, redirectValid=0, all CSRs at reset values.
- **Masked writes:**
  - Write 0xFFFF_FFFF to mepc → reads 0xFFFF_FFFC.
  - Write to mtvec → bits1:0 read 0.
  - Write to 0x342 is stored; write to 0xF11 is ignored and reads 0.
- **Counter** (with TRAP_SEQUENCER_COUNTER_EN): 3 traps plus 1 mret → 0x7C0 reads 3. Preload scenario via force to 0xFFFF_FFFF, then one trap → reads 0.
